// File: rtl/sram_sort_master_pkg.sv
// Shared types and constants for the in-place SRAM bubble sorter.
// The state encoding is exported so checkers can decode the debug state output.
package sram_sort_master_pkg;

    localparam int SWAP_CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_CMP  = 3'd3,
        S_WR_A = 3'd4,
        S_WR_B = 3'd5,
        S_NEXT = 3'd6,
        S_DONE = 3'd7
    } state_t;

    // Saturating increment; the counter sticks at all-ones.
    function automatic logic [SWAP_CNT_W-1:0] sat_inc(input logic [SWAP_CNT_W-1:0] v);
        return (v == {SWAP_CNT_W{1'b1}}) ? v : v + SWAP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/sram_sort_master.sv
// Single-port SRAM initiator that bubble-sorts N words at BASE..BASE+N-1 in place,
// ascending unsigned, with an early exit after a pass that makes no swap.
module sram_sort_master
    import sram_sort_master_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int BASE   = 0,
    parameter int N      = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [SWAP_CNT_W-1:0] swaps,
    output logic [ADDR_W-1:0]     Dir,
    output logic [DATA_W-1:0]     Dato_e,
    output logic                  En,
    output logic                  We,
    input  logic [DATA_W-1:0]     Dato_s,
    output state_t                dbg_state_o
);

    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE);
    localparam int                LAST_I    = (N < 2) ? 0 : N - 1;
    localparam logic [ADDR_W-1:0] LAST_INIT = ADDR_W'(LAST_I);
    localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       i_q, i_d;
    logic [ADDR_W-1:0]       last_q, last_d;
    logic                    flag_q, flag_d;
    logic [DATA_W-1:0]       a_q, a_d;
    logic [DATA_W-1:0]       b_q, b_d;
    logic [SWAP_CNT_W-1:0]   swaps_q, swaps_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            last_q  <= LAST_INIT;
            flag_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            swaps_q <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            last_q  <= last_d;
            flag_q  <= flag_d;
            a_q     <= a_d;
            b_q     <= b_d;
            swaps_q <= swaps_d;
        end
    end

    // SRAM outputs depend only on registered state, so a reset clears them immediately.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        last_d  = last_q;
        flag_d  = flag_q;
        a_d     = a_q;
        b_d     = b_q;
        swaps_d = swaps_q;
        Dir     = '0;
        Dato_e  = '0;
        En      = 1'b0;
        We      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    swaps_d = '0;
                    i_d     = '0;
                    last_d  = LAST_INIT;
                    flag_d  = 1'b0;
                    state_d = (N < 2) ? S_DONE : S_RD_A;
                end
            end
            S_RD_A: begin
                Dir     = BASE_A + i_q;
                En      = 1'b1;
                a_d     = Dato_s;
                state_d = S_RD_B;
            end
            S_RD_B: begin
                Dir     = BASE_A + i_q + ONE_A;
                En      = 1'b1;
                b_d     = Dato_s;
                state_d = S_CMP;
            end
            S_CMP: begin
                // Strict compare keeps equal words in place.
                state_d = (a_q > b_q) ? S_WR_A : S_NEXT;
            end
            S_WR_A: begin
                Dir     = BASE_A + i_q;
                Dato_e  = b_q;
                En      = 1'b1;
                We      = 1'b1;
                state_d = S_WR_B;
            end
            S_WR_B: begin
                Dir     = BASE_A + i_q + ONE_A;
                Dato_e  = a_q;
                En      = 1'b1;
                We      = 1'b1;
                flag_d  = 1'b1;
                swaps_d = sat_inc(swaps_q);
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if ((i_q + ONE_A) < last_q) begin
                    i_d     = i_q + ONE_A;
                    state_d = S_RD_A;
                end else if (!flag_q || (last_q == ONE_A)) begin
                    state_d = S_DONE;
                end else begin
                    last_d  = last_q - ONE_A;
                    i_d     = '0;
                    flag_d  = 1'b0;
                    state_d = S_RD_A;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign swaps       = swaps_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_sort_master.sv
// Bench for sram_sort_master: a behavioural SRAM responder plus a reference model
// that derives the sorted array, swap count and completion latency from the input.
module tb_sram_sort_master;
    import sram_sort_master_pkg::*;

    localparam int NE    = 12;
    localparam int BASEA = 0;
    localparam int LIMIT = 5000;

    typedef logic [7:0] arr_t [NE];

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main DUT (N=12)
    logic        start = 1'b0;
    logic        busy, done, En, We;
    logic [15:0] swaps;
    logic [7:0]  Dir, Dato_e, Dato_s;
    state_t      dbg_state;

    // degenerate DUT (N=1)
    logic        start1 = 1'b0;
    logic        busy1, done1, En1, We1;
    logic [15:0] swaps1;
    logic [7:0]  Dir1, Dato_e1;
    logic [7:0]  Dato_s1 = 8'h00;
    state_t      dbg_state1;

    sram_sort_master #(.ADDR_W(8), .DATA_W(8), .BASE(BASEA), .N(NE)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .swaps(swaps),
        .Dir(Dir), .Dato_e(Dato_e), .En(En), .We(We), .Dato_s(Dato_s),
        .dbg_state_o(dbg_state)
    );

    sram_sort_master #(.ADDR_W(8), .DATA_W(8), .BASE(0), .N(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .swaps(swaps1),
        .Dir(Dir1), .Dato_e(Dato_e1), .En(En1), .We(We1), .Dato_s(Dato_s1),
        .dbg_state_o(dbg_state1)
    );

    // SRAM responder: combinational read, write on the rising edge
    logic [7:0] mem [256];
    logic       load_req = 1'b0;
    arr_t       load_vals;
    assign Dato_s = mem[Dir];

    always @(posedge clk) begin
        if (load_req) begin
            for (int k = 0; k < NE; k++) mem[BASEA + k] <= load_vals[k];
        end else if (En && We) begin
            mem[Dir] <= Dato_e;
        end
    end

    int en1_seen = 0;
    always @(posedge clk) if (En1 || We1) en1_seen++;

    // scoreboard
    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference: sorted order, swaps = inversion count, passes = max left displacement + 1.
    task automatic model(input arr_t v, output arr_t s, output int sw, output int cyc);
        int q[$];
        int d, left, p, cmp;
        sw = 0;
        d  = 0;
        for (int i = 0; i < NE; i++) begin
            left = 0;
            for (int j = 0; j < i; j++) if (v[j] > v[i]) left++;
            sw += left;
            if (left > d) d = left;
            q.push_back(int'(v[i]));
        end
        q.sort();
        for (int k = 0; k < NE; k++) s[k] = q[k][7:0];
        p   = (d + 1 < NE - 1) ? d + 1 : NE - 1;
        cmp = 0;
        for (int k = 1; k <= p; k++) cmp += NE - k;
        cyc = 4 * cmp + 2 * sw + 1;
    endtask

    task automatic load(input arr_t v);
        @(negedge clk);
        load_vals = v;
        load_req  = 1'b1;
        @(negedge clk);
        load_req  = 1'b0;
    endtask

    // driver: load, pulse start, watch the run, then compare against the model
    task automatic run_sort(input string name, input arr_t v, input int pulse_at);
        arr_t s;
        int   exp_sw, exp_cyc, cyc, writes;
        logic got_done;
        model(v, s, exp_sw, exp_cyc);
        load(v);
        start = 1'b1;
        cyc = 0;
        writes = 0;
        got_done = 1'b0;
        while (!got_done && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            start = (cyc == pulse_at);
            if (We) begin
                writes++;
                check({name, "_we_needs_en"}, {31'd0, En}, 32'd1);
                check({name, "_wr_dir_in_range"},
                      {31'd0, (int'(Dir) >= BASEA) && (int'(Dir) < BASEA + NE)}, 32'd1);
            end
            if (done) got_done = 1'b1;
        end
        start = 1'b0;
        check({name, "_done_seen"}, {31'd0, got_done}, 32'd1);
        check({name, "_done_cycle"}, cyc, exp_cyc);
        check({name, "_swaps"}, {16'd0, swaps}, exp_sw);
        check({name, "_write_cycles"}, writes, 2 * exp_sw);
        @(negedge clk);
        check({name, "_done_one_cycle"}, {31'd0, done}, 32'd0);
        check({name, "_idle_after"}, {31'd0, busy}, 32'd0);
        exp_q.delete();
        for (int k = 0; k < NE; k++) exp_q.push_back({24'd0, s[k]});
        for (int k = 0; k < NE; k++) begin
            check($sformatf("%s_word%0d", name, k), {24'd0, mem[BASEA + k]}, exp_q.pop_front());
        end
        repeat (3) @(negedge clk);
        check({name, "_swaps_hold"}, {16'd0, swaps}, exp_sw);
    endtask

    arr_t v;
    int   bound;

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 8'h00;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_en", {31'd0, En}, 32'd0);
        check("rst_we", {31'd0, We}, 32'd0);
        check("rst_dir", {24'd0, Dir}, 32'd0);
        check("rst_dato_e", {24'd0, Dato_e}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_swaps", {16'd0, swaps}, 32'd0);
        check("rst_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
        rst = 1'b0;
        @(negedge clk);

        // directed arrays
        v = '{8'd90, 8'd80, 8'd40, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd100, 8'd101, 8'd102};
        run_sort("mixed", v, 0);
        check("mixed_swaps_abs", {16'd0, swaps}, 32'd33);
        for (int k = 0; k < NE; k++) v[k] = 8'(k + 1);
        run_sort("sorted", v, 0);
        for (int k = 0; k < NE; k++) v[k] = 8'(NE - k);
        run_sort("reverse", v, 0);
        check("reverse_swaps_abs", {16'd0, swaps}, 32'd66);

        // start pulsed while busy is ignored; a reloaded second run recomputes swaps
        for (int k = 0; k < NE; k++) v[k] = 8'($urandom_range(0, 255));
        run_sort("busy_pulse", v, 10);
        for (int k = 0; k < NE; k++) v[k] = 8'($urandom_range(0, 255));
        run_sort("rerun", v, 0);

        // randomized arrays, some with many duplicates
        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < NE; k++)
                v[k] = 8'((t % 2 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 3));
            run_sort($sformatf("rand%0d", t), v, 0);
        end

        // reset landing in a write cycle
        for (int k = 0; k < NE; k++) v[k] = 8'(NE - k);
        load(v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bound = 0;
        while (dbg_state != S_WR_A && bound < LIMIT) begin
            @(negedge clk);
            bound++;
        end
        check("wr_a_reached", {31'd0, dbg_state == S_WR_A}, 32'd1);
        check("wr_a_en_we", {30'd0, En, We}, 32'd3);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_en", {31'd0, En}, 32'd0);
        check("rst_mid_we", {31'd0, We}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NE; k++) v[k] = 8'($urandom_range(0, 255));
        run_sort("after_rst", v, 0);

        // N=1 instance: straight to DONE, never touches the SRAM
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("n1_done", {31'd0, done1}, 32'd1);
        check("n1_busy", {31'd0, busy1}, 32'd1);
        check("n1_swaps", {16'd0, swaps1}, 32'd0);
        @(negedge clk);
        check("n1_done_cleared", {31'd0, done1}, 32'd0);
        check("n1_idle", {31'd0, busy1}, 32'd0);
        check("n1_dir", {24'd0, Dir1 | Dato_e1}, 32'd0);
        check("n1_state", {29'd0, dbg_state1}, {29'd0, S_IDLE});
        check("n1_no_sram_access", en1_seen, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
